// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared OTTER types and constants used by the fetch front end
package otter_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  // Injected by decode when it needs a bubble (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_queue_if.sv
// rtl/otter_fetch_queue_if.sv - IMEM request/response, redirect and decode handshake bundle
interface otter_fetch_queue_if #(
  parameter int ADDR_W          = 32,
  parameter int INSTR_W         = 32,
  parameter int MAX_OUTSTANDING = 2
);
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);

  logic               IMEM_REQ_VALID;
  logic               IMEM_REQ_READY;
  logic [ADDR_W-1:0]  IMEM_REQ_ADDR;
  logic               IMEM_RSP_VALID;
  logic [INSTR_W-1:0] IMEM_RSP_DATA;
  logic               REDIRECT_VALID;
  logic [ADDR_W-1:0]  REDIRECT_PC;
  logic               IF_VALID;
  logic               IF_READY;
  logic [ADDR_W-1:0]  IF_PC;
  logic [INSTR_W-1:0] IF_INSTR;
  logic [IW-1:0]      INFLIGHT;

  modport master (
    output IMEM_REQ_VALID, IMEM_REQ_ADDR, IF_VALID, IF_PC, IF_INSTR, INFLIGHT,
    input  IMEM_REQ_READY, IMEM_RSP_VALID, IMEM_RSP_DATA, REDIRECT_VALID, REDIRECT_PC, IF_READY
  );

  modport slave (
    input  IMEM_REQ_VALID, IMEM_REQ_ADDR, IF_VALID, IF_PC, IF_INSTR, INFLIGHT,
    output IMEM_REQ_READY, IMEM_RSP_VALID, IMEM_RSP_DATA, REDIRECT_VALID, REDIRECT_PC, IF_READY
  );

endinterface

// File: rtl/otter_fifo.sv
// rtl/otter_fifo.sv - power-of-two circular FIFO with flush, count, full and empty
module otter_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  T                       wdata_i,
  output T                       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PW'(1);
      if (pop_i)  head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/otter_fetch_queue.sv
// rtl/otter_fetch_queue.sv - decoupled OTTER fetch: PC generator, credited IMEM requests, prefetch queue
module otter_fetch_queue
  import otter_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter int                INSTR_W         = 32,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC       = '0
) (
  input logic                 CLK,
  input logic                 RESET_N,
  otter_fetch_queue_if.master bus
);
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + IW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_tgt;
  logic [IW-1:0]     inflight_q, inflight_d, drop_q, drop_d;
  logic [CW-1:0]     q_count;
  logic [SW-1:0]     q_used;
  logic              q_full, q_empty, req_valid, req_fire, rsp_keep, if_valid, pop;
  fetch_entry_t      wr_entry, head_entry;

  assign redirect_tgt = {bus.REDIRECT_PC[ADDR_W-1:2], 2'b00};

  // Slots already held plus slots promised to live (non-dropped) requests.
  assign q_used    = SW'(q_count) + SW'(inflight_q) - SW'(drop_q);
  assign req_valid = RESET_N && !bus.REDIRECT_VALID && (q_used < SW'(DEPTH))
                     && (inflight_q < IW'(MAX_OUTSTANDING));
  assign req_fire  = req_valid && bus.IMEM_REQ_READY;
  assign rsp_keep  = bus.IMEM_RSP_VALID && (drop_q == '0) && !bus.REDIRECT_VALID;
  assign if_valid  = !q_empty && !bus.REDIRECT_VALID;
  assign pop       = if_valid && bus.IF_READY;
  assign wr_entry  = '{pc: rsp_pc_q, instr: bus.IMEM_RSP_DATA};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + IW'(req_fire) - IW'(bus.IMEM_RSP_VALID);
    if (bus.REDIRECT_VALID) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      drop_d     = inflight_q - IW'(bus.IMEM_RSP_VALID);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + ADDR_W'(INSTR_BYTES);
      else if (bus.IMEM_RSP_VALID) drop_d = drop_q - IW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_pc_q <= RESET_VEC;
      rsp_pc_q   <= RESET_VEC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  otter_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push_i  (rsp_keep),
    .pop_i   (pop),
    .flush_i (bus.REDIRECT_VALID),
    .wdata_i (wr_entry),
    .rdata_o (head_entry),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign bus.IMEM_REQ_VALID = req_valid;
  assign bus.IMEM_REQ_ADDR  = fetch_pc_q;
  assign bus.IF_VALID       = if_valid;
  assign bus.IF_PC          = head_entry.pc;
  assign bus.IF_INSTR       = head_entry.instr;
  assign bus.INFLIGHT       = inflight_q;

  a_rsp_without_req: assert property (@(posedge CLK) disable iff (!RESET_N)
    !(bus.IMEM_RSP_VALID && inflight_q == '0));
  a_count_bound: assert property (@(posedge CLK) disable iff (!RESET_N)
    q_count <= CW'(DEPTH));
  a_push_into_full: assert property (@(posedge CLK) disable iff (!RESET_N)
    !(rsp_keep && q_full && !pop));

endmodule

// File: tb/tb_otter_fetch_queue.sv
// tb/tb_otter_fetch_queue.sv - scoreboard bench for otter_fetch_queue with a variable-latency IMEM model
module tb_otter_fetch_queue;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          lat;
  bit          stall_rand;
  int          total;
  int          bad;
  logic [31:0] exp_q [$];
  mreq_t       mq [$];

  otter_fetch_queue_if #(.ADDR_W(32), .INSTR_W(32), .MAX_OUTSTANDING(2)) bus ();

  otter_fetch_queue #(
    .ADDR_W          (32),
    .INSTR_W         (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_VEC       (32'h0)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // In-order IMEM: capture handshakes before the edge, answer lat cycles later.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.IMEM_REQ_VALID && bus.IMEM_REQ_READY)
      mq.push_back('{addr: bus.IMEM_REQ_ADDR, due: cyc + lat});
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    bus.IMEM_REQ_READY = stall_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
      bus.IMEM_RSP_VALID = 1'b1;
      bus.IMEM_RSP_DATA  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.IMEM_RSP_VALID = 1'b0;
      bus.IMEM_RSP_DATA  = '0;
    end
  end

  // Monitor: every accepted head must match the next expected PC.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (rst_n) begin
      chk("inflight_max", 32'(bus.INFLIGHT <= 2'd2), 32'd1);
      if (bus.IF_VALID && bus.IF_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got pc %h want none (cycle %0d)", bus.IF_PC, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", bus.IF_PC, e);
          chk("if_instr", bus.IF_INSTR, instr_of(e));
        end
      end
    end
  end

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset(input bit rdy);
    rst_n = 1'b0;
    mq.delete();
    exp_q.delete();
    bus.IMEM_RSP_VALID = 1'b0;
    bus.REDIRECT_VALID = 1'b0;
    bus.REDIRECT_PC    = '0;
    bus.IF_READY       = rdy;
    repeat (2) step();
    #1;
    chk("rst_req_valid", 32'(bus.IMEM_REQ_VALID), 32'd0);
    chk("rst_if_valid", 32'(bus.IF_VALID), 32'd0);
    chk("rst_inflight", 32'(bus.INFLIGHT), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (exp_q.size() > 0 && k < bound) begin
      step();
      k++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left want 0", exp_q.size());
    end
    bus.IF_READY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic vb [1:5];
    bit   found;
    rst_n = 1'b0;
    cyc = 0;
    lat = 1;
    stall_rand = 1'b0;
    total = 0;
    bad = 0;
    bus.IMEM_REQ_READY = 1'b1;
    bus.IMEM_RSP_VALID = 1'b0;
    bus.IMEM_RSP_DATA  = '0;
    bus.REDIRECT_VALID = 1'b0;
    bus.REDIRECT_PC    = '0;
    bus.IF_READY       = 1'b0;

    // Streaming from reset: 0,4,8,12 back to back, two cycles after first request.
    do_reset(1'b1);
    push_seq(32'h0, 4);
    #1;
    chk("first_req_valid", 32'(bus.IMEM_REQ_VALID), 32'd1);
    chk("first_req_addr", bus.IMEM_REQ_ADDR, 32'h0);
    for (int n = 1; n <= 5; n++) begin
      step();
      #1;
      vb[n] = bus.IF_VALID;
    end
    chk("if_valid_c1", 32'(vb[1]), 32'd0);
    chk("if_valid_c2", 32'(vb[2]), 32'd1);
    chk("if_valid_c3", 32'(vb[3]), 32'd1);
    chk("if_valid_c4", 32'(vb[4]), 32'd1);
    chk("if_valid_c5", 32'(vb[5]), 32'd1);
    wait_drain(20);

    // Decode stalled: queue fills with 0..12 and requests stop on credit.
    do_reset(1'b0);
    repeat (10) step();
    #1;
    chk("full_req_valid", 32'(bus.IMEM_REQ_VALID), 32'd0);
    chk("full_inflight", 32'(bus.INFLIGHT), 32'd0);
    chk("full_if_valid", 32'(bus.IF_VALID), 32'd1);
    chk("full_if_pc", bus.IF_PC, 32'h0);
    push_seq(32'h0, 8);
    bus.IF_READY = 1'b1;
    wait_drain(60);

    // Redirect with two requests outstanding: both stale responses dropped.
    lat = 3;
    do_reset(1'b1);
    push_seq(32'h100, 4);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (bus.INFLIGHT == 2'd2) found = 1'b1;
    end
    chk("inflight_reached_2", 32'(found), 32'd1);
    bus.REDIRECT_VALID = 1'b1;
    bus.REDIRECT_PC    = 32'h0000_0103;
    #1;
    chk("redir_if_valid", 32'(bus.IF_VALID), 32'd0);
    chk("redir_req_valid", 32'(bus.IMEM_REQ_VALID), 32'd0);
    step();
    bus.REDIRECT_VALID = 1'b0;
    #1;
    chk("redir_inflight_after", 32'(bus.INFLIGHT), 32'd2);
    wait_drain(60);

    // Redirect coinciding with a response while one is outstanding.
    lat = 1;
    do_reset(1'b1);
    push_seq(32'h200, 4);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (bus.IF_VALID && bus.INFLIGHT == 2'd1 && bus.IMEM_RSP_VALID) found = 1'b1;
    end
    chk("rsp_redirect_setup", 32'(found), 32'd1);
    bus.REDIRECT_VALID = 1'b1;
    bus.REDIRECT_PC    = 32'h0000_0200;
    #1;
    chk("rsp_redir_if_valid", 32'(bus.IF_VALID), 32'd0);
    chk("rsp_redir_req_valid", 32'(bus.IMEM_REQ_VALID), 32'd0);
    step();
    bus.REDIRECT_VALID = 1'b0;
    #1;
    chk("rsp_redir_inflight", 32'(bus.INFLIGHT), 32'd0);
    chk("rsp_redir_flushed", 32'(bus.IF_VALID), 32'd0);
    wait_drain(60);

    // Random memory stalls: order preserved.
    stall_rand = 1'b1;
    do_reset(1'b1);
    push_seq(32'h0, 16);
    wait_drain(400);
    stall_rand = 1'b0;

    // Asynchronous reset mid-stream, then restart at the reset vector.
    do_reset(1'b1);
    push_seq(32'h0, 8);
    repeat (4) step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    mq.delete();
    bus.IMEM_RSP_VALID = 1'b0;
    #1;
    chk("async_if_valid", 32'(bus.IF_VALID), 32'd0);
    chk("async_req_valid", 32'(bus.IMEM_REQ_VALID), 32'd0);
    chk("async_inflight", 32'(bus.INFLIGHT), 32'd0);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    push_seq(32'h0, 4);
    #1;
    chk("restart_req_valid", 32'(bus.IMEM_REQ_VALID), 32'd1);
    chk("restart_req_addr", bus.IMEM_REQ_ADDR, 32'h0);
    wait_drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
